output_merger_nway: RTL and testbench

// - Parametrised N-wedge output merger. Drains one event per enabled wedge FIFO in ascending wedge order and forwards data words to a single output FIFO.
// - Strips each wedge's end-event (EE) word, checks event IDs across wedges, and emits one merged EE word per event.
// - Sits between the per-wedge fitter output FIFOs and the board output FIFO. Replaces the fixed 4-wedge merger FSM.

---
 rtl/output_merger_nway.sv | 218 +++++++++++++++++++++
 tb/tb_output_merger_nway.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_merger_nway.sv
// output_merger_nway
// Drains one event per enabled wedge FIFO in ascending wedge order into a
// single output FIFO. Per-wedge end-event (EE) words are stripped, their
// event IDs are cross-checked against the first wedge's EE, and one merged
// EE word (error fields ORed together) closes every event.
// Optional feature: define MERGER_WATCHDOG_EN to build a READ-stall watchdog
// that escalates to the error path after TIMEOUT consecutive stalled cycles.
module output_merger_nway #(
    parameter int N_WEDGE = 4,
    parameter int DATA_W  = 32,
    parameter int EID_W   = 8,
    parameter int ERR_LSB = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [N_WEDGE-1:0]          wedge_enable,
    input  logic [N_WEDGE-1:0]          in_empty,
    input  logic [N_WEDGE*DATA_W-1:0]   in_data,
    output logic [N_WEDGE-1:0]          in_re,
    input  logic                        out_hfull,
    output logic                        out_we,
    output logic [DATA_W-1:0]           out_data,
    output logic                        error_out,
    output logic [1:0]                  err_code,
    output logic [2:0]                  state_out,
    output logic [15:0]                 event_count
);

    localparam int CUR_W = $clog2(N_WEDGE);
    localparam logic [N_WEDGE-1:0] WEDGE0_BIT = {{(N_WEDGE-1){1'b0}}, 1'b1};

    if (N_WEDGE < 2 || N_WEDGE > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("output_merger_nway: N_WEDGE or TIMEOUT out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_EMIT      = 3'd2,
        ST_ERROR_OUT = 3'd3,
        ST_ERROR     = 3'd4
    } state_t;

    // Index of the lowest set bit of a wedge mask (0 when the mask is empty).
    function automatic logic [CUR_W-1:0] lowest_bit(input logic [N_WEDGE-1:0] mask);
        logic [CUR_W-1:0] idx;
        idx = '0;
        for (int i = N_WEDGE - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = CUR_W'(i);
            end
        end
        return idx;
    endfunction

    // Merged EE word: reference EE with its error field replaced and EE flag forced.
    function automatic logic [DATA_W-1:0] merge_ee(input logic [DATA_W-1:0] ref_word,
                                                   input logic [7:0]        err);
        logic [DATA_W-1:0] w;
        w = ref_word;
        w[ERR_LSB +: 8] = err;
        w[DATA_W-1] = 1'b1;
        return w;
    endfunction

    state_t                 state_r;
    logic [N_WEDGE-1:0]     en_reg_r;
    logic [CUR_W-1:0]       cur_r;
    logic [DATA_W-1:0]      ref_word_r;
    logic                   have_ref_r;
    logic [7:0]             err_acc_r;
    logic                   out_we_r;
    logic [DATA_W-1:0]      out_data_r;
    logic                   error_out_r;
    logic [1:0]             err_code_r;
    logic [15:0]            event_count_r;

    logic [DATA_W-1:0]      head_s;
    logic                   read_s;
    logic                   is_ee_s;
    logic                   mismatch_s;
    logic [N_WEDGE-1:0]     rem_s;
    logic                   has_next_s;
    logic [CUR_W-1:0]       next_cur_s;
    logic                   wd_hit_s;

    // Head-word decode, read qualification and search for the next enabled wedge.
    always_comb begin
        head_s  = in_data[cur_r*DATA_W +: DATA_W];
        is_ee_s = head_s[DATA_W-1];
        if (state_r == ST_READ) begin
            read_s = !in_empty[cur_r] && !out_hfull;
        end else begin
            read_s = 1'b0;
        end
        if (read_s && is_ee_s && have_ref_r) begin
            mismatch_s = (head_s[EID_W-1:0] != ref_word_r[EID_W-1:0]);
        end else begin
            mismatch_s = 1'b0;
        end
        rem_s = '0;
        for (int i = 0; i < N_WEDGE; i++) begin
            rem_s[i] = en_reg_r[i] && (i > int'(cur_r));
        end
        has_next_s = |rem_s;
        next_cur_s = lowest_bit(rem_s);
    end

`ifdef MERGER_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wd_cnt_r;
    logic        wd_stall_s;

    assign wd_stall_s = (state_r == ST_READ) && in_empty[cur_r];
    assign wd_hit_s   = wd_stall_s && (wd_cnt_r == WD_LAST);

    // Stall counter: counts consecutive empty-head cycles in READ, cleared otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_r <= 16'd0;
        end else if (wd_stall_s) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
        end else begin
            wd_cnt_r <= 16'd0;
        end
    end
`else
    assign wd_hit_s = 1'b0;
`endif

    // Merger FSM with registered output strobes, data and status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            en_reg_r      <= '0;
            cur_r         <= '0;
            ref_word_r    <= '0;
            have_ref_r    <= 1'b0;
            err_acc_r     <= 8'd0;
            out_we_r      <= 1'b0;
            out_data_r    <= '0;
            error_out_r   <= 1'b0;
            err_code_r    <= 2'b00;
            event_count_r <= 16'd0;
        end else begin
            out_we_r    <= 1'b0;
            error_out_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if ((wedge_enable != '0) && !out_hfull) begin
                        en_reg_r   <= wedge_enable;
                        cur_r      <= lowest_bit(wedge_enable);
                        have_ref_r <= 1'b0;
                        err_acc_r  <= 8'd0;
                        state_r    <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (read_s) begin
                        if (!is_ee_s) begin
                            out_we_r   <= 1'b1;
                            out_data_r <= head_s;
                        end else begin
                            err_acc_r <= err_acc_r | head_s[ERR_LSB +: 8];
                            if (!have_ref_r) begin
                                ref_word_r <= head_s;
                                have_ref_r <= 1'b1;
                            end
                            if (mismatch_s) begin
                                err_code_r  <= 2'b01;
                                error_out_r <= 1'b1;
                                state_r     <= ST_ERROR_OUT;
                            end else if (has_next_s) begin
                                cur_r <= next_cur_s;
                            end else begin
                                state_r <= ST_EMIT;
                            end
                        end
                    end else if (wd_hit_s) begin
                        err_code_r  <= 2'b10;
                        error_out_r <= 1'b1;
                        state_r     <= ST_ERROR_OUT;
                    end
                end
                ST_EMIT: begin
                    if (!out_hfull) begin
                        out_we_r      <= 1'b1;
                        out_data_r    <= merge_ee(ref_word_r, err_acc_r);
                        event_count_r <= event_count_r + 16'd1;
                        err_acc_r     <= 8'd0;
                        have_ref_r    <= 1'b0;
                        state_r       <= ST_IDLE;
                    end
                end
                ST_ERROR_OUT: begin
                    state_r <= ST_ERROR;
                end
                ST_ERROR: begin
                    state_r <= ST_ERROR;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_re       = read_s ? (WEDGE0_BIT << cur_r) : '0;
    assign out_we      = out_we_r;
    assign out_data    = out_data_r;
    assign error_out   = error_out_r;
    assign err_code    = err_code_r;
    assign state_out   = state_r;
    assign event_count = event_count_r;

endmodule

// File: tb/tb_output_merger_nway.sv
// tb_output_merger_nway
// Randomized bench: wedge FIFOs are modelled as arrays with pointers, each
// event's expected output stream is built from the merging rules while the
// stimulus is generated, and the DUT's written words are compared in order.
`timescale 1ns/1ps
module tb_output_merger_nway;

    localparam int NW = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NW-1:0]     wedge_enable;
    logic [NW-1:0]     in_empty;
    logic [NW*DW-1:0]  in_data;
    logic [NW-1:0]     in_re;
    logic              out_hfull;
    logic              out_we;
    logic [DW-1:0]     out_data;
    logic              error_out;
    logic [1:0]        err_code;
    logic [2:0]        state_out;
    logic [15:0]       event_count;

    always #5 clock = ~clock;

    output_merger_nway #(
        .N_WEDGE(NW), .DATA_W(DW), .EID_W(8), .ERR_LSB(8), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .wedge_enable(wedge_enable),
        .in_empty(in_empty), .in_data(in_data), .in_re(in_re),
        .out_hfull(out_hfull), .out_we(out_we), .out_data(out_data),
        .error_out(error_out), .err_code(err_code), .state_out(state_out),
        .event_count(event_count)
    );

    // Wedge FIFO model (FWFT): written by the stimulus, popped by in_re.
    logic [DW-1:0] fifo_mem [NW][256];
    logic [7:0]    wp [NW];
    logic [7:0]    rp [NW];
    int            rd_cnt [NW];
    logic          fifo_init;

    // Output capture and protocol monitors.
    logic [DW-1:0] obs_mem [4096];
    int            obs_n;
    int            hf_viol;
    int            bad_re;
    int            err_pulses;
    int            re_active;

    int            n_cmp;
    int            n_mis;
    int            hf_mode;
    logic [DW-1:0] exp_q [$];
    int            exp_reads;

    // FWFT head presentation from the model arrays.
    always_comb begin
        for (int k = 0; k < NW; k++) begin
            in_empty[k] = (rp[k] == wp[k]);
            in_data[k*DW +: DW] = fifo_mem[k][rp[k]];
        end
    end

    // FIFO pops on accepted reads.
    always @(posedge clock) begin
        for (int k = 0; k < NW; k++) begin
            if (fifo_init) begin
                rp[k]     <= 8'd0;
                rd_cnt[k] <= 0;
            end else if (in_re[k]) begin
                rp[k]     <= rp[k] + 8'd1;
                rd_cnt[k] <= rd_cnt[k] + 1;
            end
        end
    end

    // Mid-cycle capture of written words and protocol observations.
    always @(negedge clock) begin
        if (fifo_init) begin
            obs_n <= 0; hf_viol <= 0; bad_re <= 0; err_pulses <= 0; re_active <= 0;
        end else begin
            if (out_we) begin
                obs_mem[obs_n[11:0]] <= out_data;
                obs_n <= obs_n + 1;
            end
            if (out_hfull && (in_re != '0)) hf_viol <= hf_viol + 1;
            if (!$onehot0(in_re)) bad_re <= bad_re + 1;
            if (error_out) err_pulses <= err_pulses + 1;
            if (in_re != '0) re_active <= re_active + 1;
        end
    end

    // Backpressure generator: 0 off, 1 toggle every 3 cycles, 2 random.
    initial begin
        int ph;
        ph = 0;
        out_hfull = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (hf_mode)
                1: begin
                    ph = ph + 1;
                    if (ph % 3 == 0) out_hfull = ~out_hfull;
                end
                2: out_hfull = ($urandom_range(0, 3) == 0);
                default: out_hfull = 1'b0;
            endcase
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int k, input logic [DW-1:0] w);
        fifo_mem[k][wp[k]] = w;
        wp[k] = wp[k] + 8'd1;
    endtask

    task automatic flush();
        for (int k = 0; k < NW; k++) wp[k] = rp[k];
    endtask

    // Load every wedge with one event and derive the expected output stream.
    // nfix<0 picks 0..3 data words per wedge; bad_k>=0 gives that wedge EID+1.
    task automatic load_event(input logic [NW-1:0] en, input int nfix, input bit pow_err,
                              input logic [7:0] eid, input int bad_k, output bit exp_err);
        logic [7:0]    or_err, e, er;
        logic [DW-1:0] ref_ee, w, ee;
        bit            have_ref, stop;
        int            n;
        or_err = 8'd0; have_ref = 1'b0; stop = 1'b0; exp_err = 1'b0; ref_ee = '0;
        exp_q.delete();
        exp_reads = 0;
        for (int k = 0; k < NW; k++) begin
            n  = (nfix >= 0) ? nfix : $urandom_range(0, 3);
            e  = (k == bad_k) ? eid + 8'd1 : eid;
            er = pow_err ? 8'(1 << k) : 8'($urandom);
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                w[DW-1] = 1'b0;
                push_word(k, w);
                if (en[k] && !stop) begin
                    exp_q.push_back(w);
                    exp_reads++;
                end
            end
            ee = $urandom;
            ee[DW-1] = 1'b1;
            ee[15:8] = er;
            ee[7:0]  = e;
            push_word(k, ee);
            if (en[k] && !stop) begin
                exp_reads++;
                or_err = or_err | er;
                if (!have_ref) begin
                    ref_ee = ee;
                    have_ref = 1'b1;
                end else if (e != ref_ee[7:0]) begin
                    stop = 1'b1;
                    exp_err = 1'b1;
                end
            end
        end
        if (!stop) begin
            ee = ref_ee;
            ee[15:8] = or_err;
            exp_q.push_back(ee);
        end
    endtask

    function automatic int total_reads();
        int s;
        s = 0;
        for (int k = 0; k < NW; k++) s += rd_cnt[k];
        return s;
    endfunction

    // Run one loaded event to completion (or to the error state) and compare.
    task automatic run_event(input string tag, input logic [NW-1:0] en, input bit exp_err);
        int         base, hv0, br0, pul0, rd0, re0, ob0, nobs;
        logic [15:0] ev0;
        bit         started, done;
        base = obs_n; hv0 = hf_viol; br0 = bad_re; pul0 = err_pulses;
        rd0 = total_reads(); ev0 = event_count;
        wedge_enable = en;
        started = 1'b0;
        for (int c = 0; c < 100 && !started; c++) begin
            @(negedge clock);
            started = (state_out != 3'd0);
        end
        wedge_enable = '0;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clock);
            if (exp_err) done = (state_out == 3'd4);
            else         done = (event_count != ev0) && (state_out == 3'd0);
        end
        check_val({tag, "_done"}, 32'(done), 32'd1);
        if (exp_err) begin
            re0 = re_active; ob0 = obs_n;
            repeat (20) @(negedge clock);
            check_val({tag, "_re_after_err"}, 32'(re_active - re0), 32'd0);
            check_val({tag, "_we_after_err"}, 32'(obs_n - ob0), 32'd0);
            check_val({tag, "_err_pulses"}, 32'(err_pulses - pul0), 32'd1);
            check_val({tag, "_err_code"}, 32'(err_code), 32'd1);
            check_val({tag, "_state"}, 32'(state_out), 32'd4);
        end else begin
            repeat (2) @(negedge clock);
            check_val({tag, "_err_code"}, 32'(err_code), 32'd0);
        end
        nobs = obs_n - base;
        check_val({tag, "_len"}, 32'(nobs), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < nobs; i++) begin
            check_val({tag, "_word"}, obs_mem[(base + i) % 4096], exp_q[i]);
        end
        check_val({tag, "_evcnt"}, 32'(event_count), 32'(exp_err ? ev0 : ev0 + 16'd1));
        check_val({tag, "_reads"}, 32'(total_reads() - rd0), 32'(exp_reads));
        check_val({tag, "_hfull_re"}, 32'(hf_viol - hv0), 32'd0);
        check_val({tag, "_onehot"}, 32'(bad_re - br0), 32'd0);
        flush();
    endtask

    task automatic do_reset();
        wedge_enable = '0;
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        flush();
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        bit e;
        bit got;
        int base;
        int stall;
        bit fired;
        n_cmp = 0; n_mis = 0; hf_mode = 0;
        wedge_enable = '0; reset_n = 1'b0; fifo_init = 1'b1;
        for (int k = 0; k < NW; k++) wp[k] = 8'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        fifo_init = 1'b0;
        check_val("rst_state", 32'(state_out), 32'd0);
        check_val("rst_we", 32'(out_we), 32'd0);
        check_val("rst_re", 32'(in_re), 32'd0);
        check_val("rst_evcnt", 32'(event_count), 32'd0);
        check_val("rst_err", 32'({error_out, err_code}), 32'd0);
        check_val("rst_data", out_data, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // T1: all wedges, 2 data words each, EID 0x05, error field 2^k.
        load_event(4'b1111, 2, 1'b1, 8'h05, -1, e);
        run_event("t1", 4'b1111, e);
        check_val("t1_ee_field", 32'(obs_mem[(obs_n - 1) % 4096][15:0]), 32'h0F05);
        check_val("t1_evcnt_abs", 32'(event_count), 32'd1);

        // T2: sparse enable, wedges 0 and 2 hold data but must never be read.
        load_event(4'b1010, 2, 1'b1, 8'h05, -1, e);
        run_event("t2", 4'b1010, e);

        // T4: backpressure toggled every 3 cycles.
        hf_mode = 1;
        load_event(4'b1111, 2, 1'b1, 8'h05, -1, e);
        run_event("t4", 4'b1111, e);
        hf_mode = 0;

        // Randomized events with random backpressure and occasional EID faults.
        hf_mode = 2;
        for (int it = 0; it < 24; it++) begin
            logic [NW-1:0] en;
            int bk;
            en = 4'($urandom_range(1, 15));
            bk = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
            load_event(en, -1, 1'b0, 8'($urandom), bk, e);
            run_event("rnd", en, e);
            if (e) do_reset();
        end
        hf_mode = 0;

        // T6: asynchronous reset in the middle of READ, then a clean event.
        load_event(4'b1111, 3, 1'b0, 8'h33, -1, e);
        base = obs_n;
        wedge_enable = 4'b1111;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            got = (state_out == 3'd1) && (obs_n > base + 1);
        end
        check_val("t6_mid_read", 32'(got), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t6_state", 32'(state_out), 32'd0);
        check_val("t6_we", 32'(out_we), 32'd0);
        check_val("t6_re", 32'(in_re), 32'd0);
        check_val("t6_data", out_data, 32'd0);
        check_val("t6_evcnt", 32'(event_count), 32'd0);
        wedge_enable = '0;
        repeat (2) @(negedge clock);
        flush();
        reset_n = 1'b1;
        @(negedge clock);
        load_event(4'b0110, 1, 1'b0, 8'h44, -1, e);
        run_event("t6_after", 4'b0110, e);

        // T3: wedge 2 carries EID 0x06 against 0x05.
        load_event(4'b1111, 2, 1'b1, 8'h05, 2, e);
        check_val("t3_model_err", 32'(e), 32'd1);
        run_event("t3", 4'b1111, e);
        do_reset();
        check_val("t3_rst_code", 32'(err_code), 32'd0);
        load_event(4'b1001, 2, 1'b1, 8'h07, -1, e);
        run_event("t3_recover", 4'b1001, e);

`ifdef MERGER_WATCHDOG_EN
        // T5: wedge 1 never delivers; watchdog fires after TO stalled cycles.
        flush();
        push_word(0, 32'h8000_0105);
        wedge_enable = 4'b0011;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clock);
            got = (state_out != 3'd0);
        end
        wedge_enable = '0;
        stall = 0; fired = 1'b0;
        for (int c = 0; c < 200 && !fired; c++) begin
            if (error_out) fired = 1'b1;
            else begin
                if (state_out == 3'd1 && in_re == '0) stall++;
                @(negedge clock);
            end
        end
        check_val("t5_fired", 32'(fired), 32'd1);
        check_val("t5_stall_cycles", 32'(stall), 32'(TO));
        check_val("t5_err_code", 32'(err_code), 32'd2);
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
